// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit handling one bit per cycle.
// Multiplication uses shift-add and division uses restoring division, both on
// operand magnitudes. The sign is applied when the last iteration completes.
// Divide-by-zero and signed overflow bypass iteration and finish one cycle
// after start.
// Optional feature: define MULDIV_DIV_EN to build the divider. If it is not
// defined, ops 1xx complete immediately with a result of 0.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [2:0] OP_MUL = 3'b000, OP_MULH = 3'b001, OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b100, OP_REM = 3'b110;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t              r_state, w_next;
  logic [2:0]          r_op;
  logic [2*WIDTH-1:0]  r_prod;      // mul: {acc, multiplier}; div: {rem, dividend/quotient}
  logic [WIDTH-1:0]    r_opnd;      // multiplicand or divisor magnitude
  logic [CW-1:0]       r_cnt;
  logic                r_neg;       // product sign, or quotient sign for divides
  logic [WIDTH-1:0]    r_result;

  logic                w_accept, w_early, w_a_sgn, w_b_sgn;
  logic [WIDTH-1:0]    w_a_mag, w_b_mag, w_early_res, w_final;
  logic [WIDTH:0]      w_sum;
  logic [2*WIDTH-1:0]  w_step, w_prod_s;

`ifdef MULDIV_DIV_EN
  logic                r_neg_rem;   // remainder follows dividend sign
  logic [WIDTH:0]      w_sh, w_diff;
  logic [WIDTH-1:0]    w_quo, w_rem;
`endif

  assign busy   = (r_state == CALC);
  assign done   = (r_state == DONE);
  assign result = r_result;

  // Request decode: operand signedness, magnitudes and early-completion cases
  always_comb begin
    w_accept    = start && (r_state != CALC);
    w_a_sgn     = a[WIDTH-1] && ((op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM));
    w_b_sgn     = b[WIDTH-1] && ((op == OP_MULH) || (op == OP_DIV) || (op == OP_REM));
    w_a_mag     = w_a_sgn ? -a : a;
    w_b_mag     = w_b_sgn ? -b : b;
    w_early     = 1'b0;
    w_early_res = '0;
`ifdef MULDIV_DIV_EN
    if (op[2]) begin
      if (b == '0) begin
        w_early     = 1'b1;
        w_early_res = op[1] ? a : '1;
      end else if (!op[0] && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1)) begin
        w_early     = 1'b1;
        w_early_res = op[1] ? '0 : a;
      end
    end
`else
    w_early = op[2];
`endif
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DONE: begin
        if (w_accept) w_next = w_early ? DONE : CALC;
        else          w_next = IDLE;
      end
      CALC:    if (r_cnt == LAST) w_next = DONE;
      default: w_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // One iteration step and the signed result that follows the final step
  always_comb begin
    w_sum  = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + {1'b0, (r_prod[0] ? r_opnd : '0)};
    w_step = {w_sum, r_prod[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
    w_sh   = r_prod[2*WIDTH-1:WIDTH-1];
    w_diff = w_sh - {1'b0, r_opnd};
    if (r_op[2]) begin
      if (!w_diff[WIDTH]) w_step = {w_diff[WIDTH-1:0], r_prod[WIDTH-2:0], 1'b1};
      else                w_step = {w_sh[WIDTH-1:0],   r_prod[WIDTH-2:0], 1'b0};
    end
    w_quo = r_neg     ? -w_step[WIDTH-1:0]       : w_step[WIDTH-1:0];
    w_rem = r_neg_rem ? -w_step[2*WIDTH-1:WIDTH] : w_step[2*WIDTH-1:WIDTH];
`endif
    w_prod_s = r_neg ? -w_step : w_step;
    w_final  = (r_op == OP_MUL) ? w_prod_s[WIDTH-1:0] : w_prod_s[2*WIDTH-1:WIDTH];
`ifdef MULDIV_DIV_EN
    if (r_op[2]) w_final = r_op[1] ? w_rem : w_quo;
`endif
  end

  // Datapath: load operands on accept, iterate in CALC, and register the result at completion
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op     <= '0;
      r_prod   <= '0;
      r_opnd   <= '0;
      r_cnt    <= '0;
      r_neg    <= 1'b0;
      r_result <= '0;
`ifdef MULDIV_DIV_EN
      r_neg_rem <= 1'b0;
`endif
    end else if (w_accept) begin
      r_op  <= op;
      r_cnt <= '0;
      r_neg <= w_a_sgn ^ w_b_sgn;
`ifdef MULDIV_DIV_EN
      r_neg_rem <= w_a_sgn;
      if (op[2]) begin
        r_prod <= {{WIDTH{1'b0}}, w_a_mag};
        r_opnd <= w_b_mag;
      end else begin
        r_prod <= {{WIDTH{1'b0}}, w_b_mag};
        r_opnd <= w_a_mag;
      end
`else
      r_prod <= {{WIDTH{1'b0}}, w_b_mag};
      r_opnd <= w_a_mag;
`endif
      if (w_early) r_result <= w_early_res;
    end else if (r_state == CALC) begin
      r_prod <= w_step;
      r_cnt  <= r_cnt + 1'b1;
      if (r_cnt == LAST) r_result <= w_final;
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (WIDTH=32).
module tb_muldiv_unit;
  localparam int W = 32;
  logic         clk = 1'b0;
  logic         rst, start;
  logic [W-1:0] a, b;
  logic [2:0]   op;
  logic         busy, done;
  logic [W-1:0] result;

  int total = 0;
  int fails = 0;
  logic [W-1:0] last_res = '0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .op(op),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present a request. Returns at the negedge of cycle 1, which is the cycle after the accepting edge.
  task automatic issue(input logic [2:0] o, input logic [W-1:0] av, input logic [W-1:0] bv);
    @(negedge clk);
    op = o; a = av; b = bv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Count cycles until done. Before done, check that busy and the held result are correct.
  // Returns positioned in the done cycle.
  task automatic wait_done(input string tag, input int cyc0, input int exp_lat, input logic [W-1:0] exp_res);
    int cyc = cyc0;
    int bad_busy = 0;
    int bad_hold = 0;
    while (!done && cyc <= 100) begin
      if (busy !== (exp_lat > 1)) bad_busy++;
      if (result !== last_res) bad_hold++;
      @(negedge clk);
      cyc++;
    end
    check({tag, " done cycle"}, cyc, exp_lat);
    check({tag, " busy profile"}, bad_busy, 0);
    check({tag, " result hold"}, bad_hold, 0);
    check({tag, " busy in done"}, busy, 1'b0);
    check({tag, " result"}, result, exp_res);
    last_res = exp_res;
  endtask

  task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] av,
                        input logic [W-1:0] bv, input logic [W-1:0] exp_res, input int exp_lat);
    issue(o, av, bv);
    wait_done(tag, 1, exp_lat, exp_res);
    @(negedge clk);
    check({tag, " done pulse width"}, done, 1'b0);
    check({tag, " result after done"}, result, exp_res);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; op = '0;
    repeat (2) @(negedge clk);
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset result", result, '0);
    rst = 1'b0;

    // Multiply ops
    run_op("MUL 7*6",       3'b000, 32'd7,         32'd6,         32'h0000002A, 33);
    run_op("MULH -1*-1",    3'b001, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'h00000000, 33);
    run_op("MULHU ff*ff",   3'b011, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'hFFFFFFFE, 33);
    run_op("MULHSU ff*ff",  3'b010, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'hFFFFFFFF, 33);
    run_op("MUL -3*5",      3'b000, 32'hFFFFFFFD,  32'd5,         32'hFFFFFFF1, 33);
    run_op("MULH -3*5",     3'b001, 32'hFFFFFFFD,  32'd5,         32'hFFFFFFFF, 33);
    run_op("MULHU 2^31*4",  3'b011, 32'h80000000,  32'd4,         32'h00000002, 33);

`ifdef MULDIV_DIV_EN
    run_op("DIV -7/2",      3'b100, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD, 33);
    run_op("REM -7/2",      3'b110, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFF, 33);
    run_op("DIVU 100/7",    3'b101, 32'd100,       32'd7,         32'h0000000E, 33);
    run_op("REMU 100/7",    3'b111, 32'd100,       32'd7,         32'h00000002, 33);
    run_op("DIVU 5/0",      3'b101, 32'd5,         32'd0,         32'hFFFFFFFF, 1);
    run_op("REMU 5/0",      3'b111, 32'd5,         32'd0,         32'h00000005, 1);
    run_op("DIV ovf",       3'b100, 32'h80000000,  32'hFFFFFFFF,  32'h80000000, 1);
    run_op("REM ovf",       3'b110, 32'h80000000,  32'hFFFFFFFF,  32'h00000000, 1);
`else
    run_op("DIV 8/2 off",   3'b100, 32'd8,         32'd2,         32'h00000000, 1);
    run_op("REMU 5/3 off",  3'b111, 32'd5,         32'd3,         32'h00000000, 1);
`endif

    // A start in CALC has no effect: the original MUL completes on schedule
    run_op("MUL 1*1", 3'b000, 32'd1, 32'd1, 32'h00000001, 33);
    issue(3'b000, 32'd7, 32'd6);
    repeat (9) @(negedge clk);
    op = 3'b011; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("ignored start", 11, 33, 32'h0000002A);
    @(negedge clk);

    // Back-to-back: a start in the DONE cycle is accepted
    issue(3'b000, 32'd2, 32'd3);
    wait_done("b2b first", 1, 33, 32'h00000006);
    op = 3'b000; a = 32'd5; b = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("b2b second", 1, 33, 32'h00000019);
    @(negedge clk);

    // Reset during an operation aborts it with no done pulse
    issue(3'b000, 32'd3, 32'd4);
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort busy", busy, 1'b0);
    check("abort done", done, 1'b0);
    check("abort result", result, '0);
    begin
      int seen = 0;
      repeat (40) begin
        @(negedge clk);
        if (done) seen++;
      end
      check("abort no done", seen, 0);
    end
    last_res = '0;

    // rst takes priority over start in the same cycle
    op = 3'b000; a = 32'd9; b = 32'd9; start = 1'b1; rst = 1'b1;
    @(negedge clk);
    start = 1'b0; rst = 1'b0;
    check("rst prio busy", busy, 1'b0);
    check("rst prio done", done, 1'b0);

    run_op("MUL after rst", 3'b000, 32'd12, 32'd12, 32'h00000090, 33);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL have port clk  input  1  rising-edge clock; the block is single-clock.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  input  1  request strobe; qualifies a, b and op.
REQ-005 SHALL have port a  input  WIDTH  operand A (multiplicand/dividend).
REQ-006 SHALL have port b  input  WIDTH  operand B (multiplier/divisor).
REQ-007 SHALL have port op  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-008 SHALL have port busy  output  1  high while an operation is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse; result valid.
REQ-010 SHALL have port result  output  WIDTH  operation result.

Function
REQ-011 SHALL implement FSM states IDLE, CALC and DONE.
REQ-012 SHALL accept start only in IDLE or DONE, latching a, b and op on that edge; start in CALC is ignored, with no effect on the running operation.
REQ-013 SHALL iterate one bit per cycle in CALC (shift-add multiply, restoring divide) for exactly WIDTH cycles, then enter DONE.
REQ-014 SHALL, for an accepted start at edge 0, assert busy from cycle 1 to cycle WIDTH and assert done in cycle WIDTH+1 (33 for WIDTH=32).
REQ-015 SHALL hold done high for exactly one cycle, and return to IDLE unless start is accepted in that same cycle.
REQ-016 SHALL hold result stable from done until the next accepted start, then keep the old value until the new done.
REQ-017 SHALL produce the low WIDTH bits of the 2*WIDTH product for MUL.
REQ-018 SHALL produce the high WIDTH bits of the 2*WIDTH product for MULH (signed x signed), MULHSU (signed a x unsigned b) and MULHU (unsigned x unsigned).
REQ-019 SHALL operate on magnitudes for signed ops and apply the sign at completion; the quotient truncates toward zero and the remainder takes the sign of the dividend.
REQ-020 SHALL, on divide-by-zero, return all-ones for DIV/DIVU and a for REM/REMU, skipping CALC so that done is asserted in cycle 1.
REQ-021 SHALL, on signed overflow (DIV/REM with a = most-negative, b = -1), return a for DIV and 0 for REM, with done in cycle 1.
REQ-022 SHALL keep busy low in IDLE and DONE.

Reset
REQ-023 SHALL, on rst high at a clock edge, enter IDLE with busy=0, done=0, result=0 and clear all iteration registers.
REQ-024 SHALL abort any in-flight operation on reset, with no done pulse for it.
REQ-025 SHALL give rst priority over a start asserted in the same cycle.

Configuration
REQ-026 SHALL, when macro MULDIV_DIV_EN is defined, implement DIV/DIVU/REM/REMU as specified above.
REQ-027 SHALL, when MULDIV_DIV_EN is undefined, omit the divider datapath; ops 1xx then return 0 with done in cycle 1 and busy never asserted, while multiply ops are unchanged.

Verification
REQ-028 SHALL cover: MUL a=7, b=6 -> result 0x0000002A; done in cycle 33, busy high cycles 1-32.
REQ-029 SHALL cover: a=b=0xFFFFFFFF with MULH -> 0x00000000, MULHU -> 0xFFFFFFFE, MULHSU -> 0xFFFFFFFF.
REQ-030 SHALL cover: DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF.
REQ-031 SHALL cover: DIVU a=5, b=0 -> 0xFFFFFFFF with done in cycle 1; REMU -> 0x00000005; DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000.
REQ-032 SHALL cover: second start at cycle 10 during MUL -> ignored, original result delivered at cycle 33; rst at cycle 15 of another operation -> busy/done/result = 0 next cycle and no done pulse.
REQ-033 SHALL cover: back-to-back start in the DONE cycle -> accepted, next done exactly WIDTH+1 cycles later; with MULDIV_DIV_EN undefined, DIV 8/2 -> 0 with done in cycle 1.
